// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem reads and feeds the IF/ID latch.
// A one-entry hold buffer absorbs a word that arrives while decode is stalled.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter logic [31:0] PC_INC  = 32'd4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] npc,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        npc_d        = npc_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;

        // HALTED is sticky: only reset leaves it, so nothing is evaluated there.
        if (state_q != S_HALTED) begin
            if (redirect_en) begin
                pc_d         = {redirect_pc[31:2], 2'b00};
                valid_d      = 1'b0;
                hold_instr_d = '0;
                hold_pc_d    = '0;
                state_d      = S_FETCH;
            end else if (halt) begin
                state_d  = S_HALTED;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (ihit) begin
                            pc_d = pc_q + PC_INC;
                            if (stall) begin
                                hold_instr_d = iload;
                                hold_pc_d    = pc_q;
                                state_d      = S_HOLD;
                            end else begin
                                instr_d  = iload;
                                pc_out_d = pc_q;
                                npc_d    = pc_q + PC_INC;
                                valid_d  = 1'b1;
                            end
                        end else if (!stall) begin
                            valid_d = 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_d  = hold_instr_q;
                            pc_out_d = hold_pc_q;
                            npc_d    = hold_pc_q + PC_INC;
                            valid_d  = 1'b1;
                            state_d  = S_FETCH;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_INIT;
            instr_q      <= '0;
            pc_out_q     <= '0;
            npc_q        <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign imemREN     = (state_q == S_FETCH);
    assign imemaddr    = pc_q;
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign npc         = npc_q;
    assign valid       = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/hold, redirect, halt, wrap.
module tb_fetch_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] npc;
    logic        valid;
    logic        halted;

    int vectors;
    int miscompares;

    fetch_unit dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ihit       (ihit),
        .iload      (iload),
        .stall      (stall),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .instruction(instruction),
        .pc_out     (pc_out),
        .npc        (npc),
        .valid      (valid),
        .halted     (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        nRST = 1'b0; ihit = 1'b0; iload = '0; stall = 1'b0;
        redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;

        #12;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_npc", npc, 32'h0);
        chk("rst_addr", imemaddr, 32'h0);
        chk("rst_ren", {31'b0, imemREN}, 32'd1);
        nRST = 1'b1;

        // Back-to-back sequential fetch
        ihit = 1'b1; iload = 32'hA500_0000; step();
        chk("seq0_instr", instruction, 32'hA500_0000);
        chk("seq0_pc_out", pc_out, 32'h0);
        chk("seq0_npc", npc, 32'h4);
        chk("seq0_valid", {31'b0, valid}, 32'd1);
        chk("seq0_addr", imemaddr, 32'h4);
        iload = 32'hA500_0004; step();
        chk("seq1_pc_out", pc_out, 32'h4);
        chk("seq1_npc", npc, 32'h8);
        chk("seq1_addr", imemaddr, 32'h8);

        // Stall with ihit at pc=8: word goes to hold buffer
        stall = 1'b1; iload = 32'h2001_0005; step();
        chk("hold_ren", {31'b0, imemREN}, 32'd0);
        chk("hold_addr", imemaddr, 32'hC);
        chk("hold_instr_kept", instruction, 32'hA500_0004);
        chk("hold_pc_out_kept", pc_out, 32'h4);
        iload = 32'hFFFF_FFFF; step();
        chk("hold2_ren", {31'b0, imemREN}, 32'd0);
        step();
        chk("hold3_ren", {31'b0, imemREN}, 32'd0);
        chk("hold3_instr_kept", instruction, 32'hA500_0004);
        stall = 1'b0; step();
        chk("rel_instr", instruction, 32'h2001_0005);
        chk("rel_pc_out", pc_out, 32'h8);
        chk("rel_npc", npc, 32'hC);
        chk("rel_valid", {31'b0, valid}, 32'd1);
        chk("rel_ren", {31'b0, imemREN}, 32'd1);
        chk("rel_addr", imemaddr, 32'hC);
        iload = 32'hA500_000C; step();
        chk("afterhold_pc_out", pc_out, 32'hC);
        chk("afterhold_addr", imemaddr, 32'h10);

        // Memory misses at pc=0x10
        ihit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("miss_valid", {31'b0, valid}, 32'd0);
            chk("miss_addr", imemaddr, 32'h10);
        end
        ihit = 1'b1; iload = 32'hA500_0010; step();
        chk("hit_instr", instruction, 32'hA500_0010);
        chk("hit_pc_out", pc_out, 32'h10);
        chk("hit_valid", {31'b0, valid}, 32'd1);
        chk("hit_addr", imemaddr, 32'h14);

        // Redirect discards a held word
        iload = 32'hA500_0014; step();
        stall = 1'b1; iload = 32'hDEAD_BEEF; step();
        chk("rd_hold_ren", {31'b0, imemREN}, 32'd0);
        redirect_en = 1'b1; redirect_pc = 32'h0000_0043; step();
        chk("rd_addr", imemaddr, 32'h40);
        chk("rd_valid", {31'b0, valid}, 32'd0);
        chk("rd_ren", {31'b0, imemREN}, 32'd1);
        redirect_en = 1'b0; stall = 1'b0; ihit = 1'b0; step();
        chk("rd_bubble_valid", {31'b0, valid}, 32'd0);
        chk("rd_no_held_word", instruction, 32'hA500_0014);
        ihit = 1'b1; iload = 32'h1111_0040; step();
        chk("rd_first_instr", instruction, 32'h1111_0040);
        chk("rd_first_pc_out", pc_out, 32'h40);
        chk("rd_first_npc", npc, 32'h44);
        chk("rd_first_valid", {31'b0, valid}, 32'd1);

        // Halt and redirect together: redirect wins
        halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h0000_0020; step();
        chk("hr_halted", {31'b0, halted}, 32'd0);
        chk("hr_addr", imemaddr, 32'h20);
        chk("hr_valid", {31'b0, valid}, 32'd0);
        chk("hr_ren", {31'b0, imemREN}, 32'd1);

        // Halt at pc=0x20
        redirect_en = 1'b0; step();
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_ren", {31'b0, imemREN}, 32'd0);
        chk("halt_valid", {31'b0, valid}, 32'd0);
        chk("halt_addr", imemaddr, 32'h20);
        halt = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h0000_0100; step();
        chk("halt_rd_ignored_addr", imemaddr, 32'h20);
        chk("halt_sticky", {31'b0, halted}, 32'd1);
        chk("halt_sticky_ren", {31'b0, imemREN}, 32'd0);
        redirect_en = 1'b0; step();
        chk("halt_still_valid", {31'b0, valid}, 32'd0);

        // Asynchronous reset clears halt
        nRST = 1'b0; #2;
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_halted", {31'b0, halted}, 32'd0);
        chk("rst2_ren", {31'b0, imemREN}, 32'd1);
        nRST = 1'b1;

        // Reset mid-HOLD loses the buffer
        ihit = 1'b1; stall = 1'b1; iload = 32'hBAD0_0000; step();
        chk("mh_ren", {31'b0, imemREN}, 32'd0);
        nRST = 1'b0; #2; nRST = 1'b1;
        chk("mh_addr", imemaddr, 32'h0);
        chk("mh_ren2", {31'b0, imemREN}, 32'd1);
        stall = 1'b0; ihit = 1'b0; step();
        chk("mh_no_word", {31'b0, valid}, 32'd0);

        // PC wrap
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFF; step();
        chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        redirect_en = 1'b0; ihit = 1'b1; iload = 32'hCAFE_F00D; step();
        chk("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap_npc", npc, 32'h0);
        chk("wrap_instr", instruction, 32'hCAFE_F00D);
        chk("wrap_next_addr", imemaddr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
